multdiv_issue_ctrl: RTL and testbench

//  Execute-stage sequencer directly upstream of the multdiv unit. Accepts one MULT/DIV op from decode,

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_issue_ctrl_if.sv | 38 +++
 rtl/multdiv_issue_ctrl_md_watchdog.sv | 27 ++
 rtl/multdiv_issue_ctrl.sv | 92 +++++++++
 tb/tb_multdiv_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and default constants for the multdiv issue sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } mdState_t;

  localparam int unsigned DEF_RSTATUS_REG    = 30;
  localparam int unsigned DEF_MULT_EXC_CODE  = 4;
  localparam int unsigned DEF_DIV_EXC_CODE   = 5;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Decode issue, multdiv unit and writeback handshakes of the multdiv issue sequencer.
interface multdiv_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_is_div;
  logic [DATA_W-1:0] issue_opA;
  logic [DATA_W-1:0] issue_opB;
  logic [REG_W-1:0]  issue_rd;
  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport master (
    input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd,
    input  md_result, md_exception, md_resultRDY, wb_ready,
    output issue_ready, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output wb_valid, wb_rd, wb_data, busy
  );

  modport slave (
    output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd,
    output md_result, md_exception, md_resultRDY, wb_ready,
    input  issue_ready, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  wb_valid, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/multdiv_issue_ctrl_md_watchdog.sv
// WAIT-state watchdog: counts WAIT cycles and flags the last permitted one.
module md_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // expired is seen during the LIMIT-th WAIT cycle so DONE follows exactly LIMIT cycles of WAIT
  assign expired = run && (count == CW'(LIMIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage issue sequencer in front of the multdiv unit.
// Optional WAIT watchdog is enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned REG_W         = 5,
  parameter int unsigned RSTATUS_REG   = DEF_RSTATUS_REG,
  parameter int unsigned MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE  = DEF_DIV_EXC_CODE
`ifdef MULTDIV_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input logic clock,
  input logic reset_n,
  multdiv_issue_ctrl_if.master bus
);
  // state   | meaning
  // S_IDLE  | ready for an op from decode
  // S_START | one-cycle start pulse to multdiv
  // S_WAIT  | waiting for md_resultRDY
  // S_DONE  | result held for writeback
  mdState_t          state;
  logic [DATA_W-1:0] opA, opB, wbData;
  logic [REG_W-1:0]  rd, wbRd;
  logic              isDiv, ctrlMult, ctrlDiv, timeout;

`ifdef MULTDIV_TIMEOUT_EN
  md_watchdog #(.LIMIT(TIMEOUT_CYCLES)) uWatchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == S_START),
    .run     (state == S_WAIT),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      opA      <= '0;
      opB      <= '0;
      rd       <= '0;
      isDiv    <= 1'b0;
      ctrlMult <= 1'b0;
      ctrlDiv  <= 1'b0;
      wbRd     <= '0;
      wbData   <= '0;
    end else begin
      ctrlMult <= 1'b0;
      ctrlDiv  <= 1'b0;
      case (state)
        S_IDLE: if (bus.issue_valid) begin
          opA      <= bus.issue_opA;
          opB      <= bus.issue_opB;
          rd       <= bus.issue_rd;
          isDiv    <= bus.issue_is_div;
          ctrlMult <= ~bus.issue_is_div;
          ctrlDiv  <= bus.issue_is_div;
          state    <= S_START;
        end
        S_START: state <= S_WAIT;
        // a real result wins over a watchdog expiry in the same cycle
        S_WAIT: if (bus.md_resultRDY || timeout) begin
          if (bus.md_resultRDY && !bus.md_exception) begin
            wbRd   <= rd;
            wbData <= bus.md_result;
          end else begin
            wbRd   <= REG_W'(RSTATUS_REG);
            wbData <= isDiv ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
          end
          state <= S_DONE;
        end
        S_DONE: if (bus.wb_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.issue_ready  = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.wb_valid     = (state == S_DONE);
  assign bus.md_operandA  = opA;
  assign bus.md_operandB  = opB;
  assign bus.md_ctrl_MULT = ctrlMult;
  assign bus.md_ctrl_DIV  = ctrlDiv;
  assign bus.wb_rd        = wbRd;
  assign bus.wb_data      = wbData;
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: directed scenarios plus random traffic against a reference model.
module tb_multdiv_issue_ctrl;
  localparam int TIMEOUT_CYCLES = 64;
`ifdef MULTDIV_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  multdiv_issue_ctrl_if #(.DATA_W(32), .REG_W(5)) bus ();
  multdiv_issue_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: one op in flight, tracked by age = clock edges since acceptance.
  // Age 0 is the start-pulse cycle; results are taken from age 1 onward until done.
  logic        mValid, mDone, mDiv;
  int          mAge;
  logic [31:0] expA, expB, expData;
  logic [4:0]  mRd, expRd;
  wire mTimeout = TIMEOUT_EN && mValid && !mDone && (mAge == TIMEOUT_CYCLES);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mValid  <= 1'b0;
      mDone   <= 1'b0;
      mDiv    <= 1'b0;
      mAge    <= 0;
      expA    <= '0;
      expB    <= '0;
      mRd     <= '0;
      expRd   <= '0;
      expData <= '0;
    end else if (!mValid) begin
      if (bus.issue_valid) begin
        mValid <= 1'b1;
        mDone  <= 1'b0;
        mAge   <= 0;
        mDiv   <= bus.issue_is_div;
        expA   <= bus.issue_opA;
        expB   <= bus.issue_opB;
        mRd    <= bus.issue_rd;
      end
    end else if (mDone) begin
      if (bus.wb_ready) mValid <= 1'b0;
    end else begin
      if (mAge >= 1 && (bus.md_resultRDY || mTimeout)) begin
        mDone <= 1'b1;
        if (bus.md_resultRDY && !bus.md_exception) begin
          expRd   <= mRd;
          expData <= bus.md_result;
        end else begin
          expRd   <= 5'd30;
          expData <= mDiv ? 32'd5 : 32'd4;
        end
      end
      mAge <= mAge + 1;
    end
  end

  always @(negedge clock) begin
    checkBit("cmp_issue_ready", bus.issue_ready, !mValid);
    checkBit("cmp_busy", bus.busy, mValid);
    checkBit("cmp_wb_valid", bus.wb_valid, mValid && mDone);
    checkBit("cmp_ctrl_mult", bus.md_ctrl_MULT, mValid && !mDone && mAge == 0 && !mDiv);
    checkBit("cmp_ctrl_div", bus.md_ctrl_DIV, mValid && !mDone && mAge == 0 && mDiv);
    check("cmp_operandA", bus.md_operandA, expA);
    check("cmp_operandB", bus.md_operandB, expB);
    if (mValid && mDone) begin
      check("cmp_wb_rd", 32'(bus.wb_rd), 32'(expRd));
      check("cmp_wb_data", bus.wb_data, expData);
    end
  end

  task automatic runOp(input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int delay, input logic [31:0] res,
                       input logic exc, output logic [4:0] gotRd, output logic [31:0] gotData,
                       output int mPulses, output int dPulses);
    int n;
    n = 0;
    while (!bus.issue_ready && n < 100) begin
      tick();
      n++;
    end
    checkBit("ready_before_issue", bus.issue_ready, 1'b1);
    bus.issue_is_div = isDiv;
    bus.issue_opA    = a;
    bus.issue_opB    = b;
    bus.issue_rd     = rd;
    bus.issue_valid  = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    mPulses = 0;
    dPulses = 0;
    repeat (delay) begin
      if (bus.md_ctrl_MULT) mPulses++;
      if (bus.md_ctrl_DIV) dPulses++;
      tick();
    end
    bus.md_resultRDY = 1'b1;
    bus.md_result    = res;
    bus.md_exception = exc;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_exception = 1'b0;
    checkBit("wb_latency", bus.wb_valid, 1'b1);
    gotRd   = bus.wb_rd;
    gotData = bus.wb_data;
  endtask

  task automatic finishWb();
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    checkBit("idle_after_wb", bus.issue_ready, 1'b1);
  endtask

  initial begin
    logic [4:0]  gRd;
    logic [31:0] gData;
    int          mp, dp;

    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_opA    = '0;
    bus.issue_opB    = '0;
    bus.issue_rd     = '0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.wb_ready     = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkBit("rst_issue_ready", bus.issue_ready, 1'b1);
    checkBit("rst_busy", bus.busy, 1'b0);
    checkBit("rst_wb_valid", bus.wb_valid, 1'b0);
    checkBit("rst_ctrl_mult", bus.md_ctrl_MULT, 1'b0);
    check("rst_operandA", bus.md_operandA, 32'h0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    reset_n = 1'b1;
    tick();

    // MULT 7 x -3, RDY 17 cycles after the pulse
    runOp(1'b0, 32'd7, 32'hFFFFFFFD, 5'd5, 17, 32'hFFFFFFEB, 1'b0, gRd, gData, mp, dp);
    check("t1_wb_rd", 32'(gRd), 32'd5);
    check("t1_wb_data", gData, 32'hFFFFFFEB);
    check("t1_mult_pulses", 32'(mp), 32'd1);
    check("t1_div_pulses", 32'(dp), 32'd0);
    finishWb();

    // exceptions redirect to $rstatus
    runOp(1'b1, 32'd100, 32'd0, 5'd9, 3, 32'h12345678, 1'b1, gRd, gData, mp, dp);
    check("t2_div_rd", 32'(gRd), 32'd30);
    check("t2_div_data", gData, 32'd5);
    check("t2_div_pulses", 32'(dp), 32'd1);
    check("t2_div_mult_pulses", 32'(mp), 32'd0);
    finishWb();
    runOp(1'b0, 32'h7FFFFFFF, 32'd2, 5'd9, 4, 32'hFFFFFFFE, 1'b1, gRd, gData, mp, dp);
    check("t2_mult_rd", 32'(gRd), 32'd30);
    check("t2_mult_data", gData, 32'd4);
    finishWb();

    // issue_valid held high across two ops
    bus.issue_is_div = 1'b0;
    bus.issue_opA    = 32'd11;
    bus.issue_opB    = 32'd3;
    bus.issue_rd     = 5'd3;
    bus.issue_valid  = 1'b1;
    tick();
    bus.issue_opA = 32'd22;
    bus.issue_opB = 32'd4;
    bus.issue_rd  = 5'd4;
    checkBit("t3_ready_start", bus.issue_ready, 1'b0);
    tick();
    checkBit("t3_ready_wait", bus.issue_ready, 1'b0);
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd33;
    tick();
    bus.md_resultRDY = 1'b0;
    checkBit("t3_ready_done", bus.issue_ready, 1'b0);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    checkBit("t3_bubble_ready", bus.issue_ready, 1'b1);
    check("t3_bubble_opA", bus.md_operandA, 32'd11);
    tick();
    bus.issue_valid = 1'b0;
    checkBit("t3_second_busy", bus.busy, 1'b1);
    checkBit("t3_second_pulse", bus.md_ctrl_MULT, 1'b1);
    check("t3_second_opA", bus.md_operandA, 32'd22);
    tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd88;
    tick();
    bus.md_resultRDY = 1'b0;
    check("t3_second_rd", 32'(bus.wb_rd), 32'd4);
    check("t3_second_data", bus.wb_data, 32'd88);
    finishWb();

    // writeback stall with a stray RDY in DONE
    runOp(1'b0, 32'd6, 32'd7, 5'd12, 2, 32'd42, 1'b0, gRd, gData, mp, dp);
    for (int i = 0; i < 10; i++) begin
      bus.md_resultRDY = (i == 3);
      bus.md_exception = (i == 3);
      bus.md_result    = 32'hDEADBEEF;
      checkBit("t4_hold_valid", bus.wb_valid, 1'b1);
      check("t4_hold_rd", 32'(bus.wb_rd), 32'd12);
      check("t4_hold_data", bus.wb_data, 32'd42);
      tick();
    end
    bus.md_resultRDY = 1'b0;
    bus.md_exception = 1'b0;
    finishWb();
    checkBit("t4_not_busy", bus.busy, 1'b0);

    // reset while waiting for the result
    bus.issue_is_div = 1'b1;
    bus.issue_opA    = 32'd50;
    bus.issue_opB    = 32'd5;
    bus.issue_rd     = 5'd7;
    bus.issue_valid  = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    repeat (2) tick();
    checkBit("t5_busy_before", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    checkBit("t5_rst_busy", bus.busy, 1'b0);
    checkBit("t5_rst_ready", bus.issue_ready, 1'b1);
    checkBit("t5_rst_wb_valid", bus.wb_valid, 1'b0);
    checkBit("t5_rst_ctrl_div", bus.md_ctrl_DIV, 1'b0);
    check("t5_rst_opA", bus.md_operandA, 32'h0);
    tick();
    reset_n = 1'b1;
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd10;
    tick();
    bus.md_resultRDY = 1'b0;
    repeat (3) begin
      checkBit("t5_no_wb_valid", bus.wb_valid, 1'b0);
      checkBit("t5_no_busy", bus.busy, 1'b0);
      tick();
    end

`ifdef MULTDIV_TIMEOUT_EN
    begin
      int n;
      bus.issue_is_div = 1'b1;
      bus.issue_opA    = 32'd9;
      bus.issue_opB    = 32'd0;
      bus.issue_rd     = 5'd13;
      bus.issue_valid  = 1'b1;
      tick();
      bus.issue_valid = 1'b0;
      n = 0;
      while (!bus.wb_valid && n < 200) begin
        tick();
        n++;
      end
      check("t6_cycles_to_done", 32'(n), 32'd65);
      checkBit("t6_wb_valid", bus.wb_valid, 1'b1);
      check("t6_wb_rd", 32'(bus.wb_rd), 32'd30);
      check("t6_wb_data", bus.wb_data, 32'd5);
      finishWb();
    end
`endif

    // random traffic, checked every cycle by the model comparison
    for (int c = 0; c < 3000; c++) begin
      bus.issue_valid  = ($urandom_range(0, 2) != 0);
      bus.issue_is_div = 1'($urandom_range(0, 1));
      bus.issue_opA    = $urandom;
      bus.issue_opB    = $urandom;
      bus.issue_rd     = 5'($urandom_range(0, 31));
      bus.md_resultRDY = ($urandom_range(0, 5) == 0);
      bus.md_result    = $urandom;
      bus.md_exception = ($urandom_range(0, 3) == 0);
      bus.wb_ready     = ($urandom_range(0, 2) != 0);
      reset_n          = ($urandom_range(0, 499) != 0);
      tick();
    end

    reset_n          = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.wb_ready     = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
